// File: rtl/rtc_access_sched.sv
// DS1302 access sequencer: arbitrates periodic 3-byte time polls against key-driven time-set writes
// and drives the byte-level serial engine one command at a time (ISSUE waits on eng_busy, WAIT on eng_done).
module rtc_access_sched #(
  parameter int POLL_CYCLES    = 12_500_000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_sec,
  input  logic [7:0] wr_min,
  input  logic [7:0] wr_hour,
  output logic       wr_ack,
  output logic       eng_start,
  output logic [7:0] eng_cmd,
  output logic [7:0] eng_wdata,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic [7:0] time_sec,
  output logic [7:0] time_min,
  output logic [7:0] time_hour,
  output logic       time_valid,
  output logic       busy,
  output logic       err
);

  localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          poll_pend;
  logic          wr_pend;
  logic          seq_wr;
  logic [2:0]    step;
  logic [7:0]    sh_sec, sh_min, sh_hour;
  logic [7:0]    wk_sec, wk_min, wk_hour;
  logic [7:0]    rd_sec, rd_min;
  logic [7:0]    next_cmd, next_wdata;
  logic          last_step;

  // Command/data for the current step of the active sequence
  always_comb begin
    next_cmd   = 8'h00;
    next_wdata = 8'h00;
    if (seq_wr) begin
      case (step)
        3'd0:    begin next_cmd = 8'h8E; next_wdata = 8'h00;            end
        3'd1:    begin next_cmd = 8'h80; next_wdata = wk_sec & 8'h7F;   end
        3'd2:    begin next_cmd = 8'h82; next_wdata = wk_min;           end
        3'd3:    begin next_cmd = 8'h84; next_wdata = wk_hour & 8'h3F;  end
        default: begin next_cmd = 8'h8E; next_wdata = 8'h80;            end
      endcase
    end else begin
      case (step)
        3'd0:    next_cmd = 8'h81;
        3'd1:    next_cmd = 8'h83;
        default: next_cmd = 8'h85;
      endcase
    end
  end

  assign last_step = seq_wr ? (step == 3'd4) : (step == 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      poll_cnt   <= PW'(POLL_CYCLES - 1);
      tmo_cnt    <= '0;
      poll_pend  <= 1'b1;
      wr_pend    <= 1'b0;
      seq_wr     <= 1'b0;
      step       <= 3'd0;
      sh_sec     <= 8'h00;
      sh_min     <= 8'h00;
      sh_hour    <= 8'h00;
      wk_sec     <= 8'h00;
      wk_min     <= 8'h00;
      wk_hour    <= 8'h00;
      rd_sec     <= 8'h00;
      rd_min     <= 8'h00;
      wr_ack     <= 1'b0;
      eng_start  <= 1'b0;
      eng_cmd    <= 8'h00;
      eng_wdata  <= 8'h00;
      time_sec   <= 8'h00;
      time_min   <= 8'h00;
      time_hour  <= 8'h00;
      time_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_ack     <= 1'b0;
      eng_start  <= 1'b0;
      time_valid <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          step    <= 3'd0;
          if (wr_pend) begin
            seq_wr  <= 1'b1;
            wr_pend <= 1'b0;
            wk_sec  <= sh_sec;
            wk_min  <= sh_min;
            wk_hour <= sh_hour;
            busy    <= 1'b1;
            state   <= ISSUE;
          end else if (poll_pend) begin
            seq_wr    <= 1'b0;
            poll_pend <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!eng_busy) begin
            eng_start <= 1'b1;
            eng_cmd   <= next_cmd;
            eng_wdata <= next_wdata;
            tmo_cnt   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (eng_done) begin
            if (!seq_wr) begin
              if (step == 3'd0) rd_sec <= eng_rdata;
              if (step == 3'd1) rd_min <= eng_rdata;
            end
            if (last_step) begin
              busy  <= 1'b0;
              state <= IDLE;
              if (seq_wr) begin
                wr_ack <= 1'b1;
              end else begin
                // All three fields land together so the display never shows a torn time
                time_sec   <= rd_sec & 8'h7F;
                time_min   <= rd_min & 8'h7F;
                time_hour  <= eng_rdata & 8'h3F;
                time_valid <= 1'b1;
              end
            end else begin
              step  <= step + 3'd1;
              state <= ISSUE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a same-cycle set beats the IDLE clear
      if (poll_cnt == '0) begin
        poll_cnt  <= PW'(POLL_CYCLES - 1);
        poll_pend <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt - PW'(1);
      end

      if (wr_req) begin
        sh_sec  <= wr_sec;
        sh_min  <= wr_min;
        sh_hour <= wr_hour;
        wr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_access_sched.sv
// Scoreboard bench for rtc_access_sched: stimulus queues expected commands/time values,
// a negedge monitor pops and compares whenever the DUT starts a command or pulses an output.
module tb_rtc_access_sched;
  localparam int POLL = 300;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_sec = 8'h00, wr_min = 8'h00, wr_hour = 8'h00;
  logic       wr_ack, eng_start, time_valid, busy, err;
  logic [7:0] eng_cmd, eng_wdata, time_sec, time_min, time_hour;
  logic       eng_busy;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rdata = 8'h00;
  logic       busy_m = 1'b0, busy_force = 1'b0;

  logic [7:0] rd_s = 8'h00, rd_m = 8'h00, rd_h = 8'h00, drop_cmd = 8'h00;
  logic [15:0] cmd_q[$];
  logic [23:0] tv_q[$];
  int checks = 0, errors = 0;
  int n_start = 0, n_tv = 0, n_ack = 0, n_err = 0;
  int cyc = 0;

  assign eng_busy = busy_m | busy_force;

  rtc_access_sched #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_sec(wr_sec), .wr_min(wr_min), .wr_hour(wr_hour),
    .wr_ack(wr_ack), .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour),
    .time_valid(time_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return n_tv;
      1:       return n_ack;
      2:       return n_err;
      default: return n_start;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int budget);
    for (int i = 0; i < budget && cnt_of(which) < target; i++) @(negedge clk);
    chk(name, cnt_of(which), target);
  endtask

  task automatic expect_read(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    cmd_q.push_back(16'h8100);
    cmd_q.push_back(16'h8300);
    cmd_q.push_back(16'h8500);
    tv_q.push_back({s, m, h});
  endtask

  task automatic pulse_wr(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    wr_sec = s; wr_min = m; wr_hour = h; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  // Serial engine model: done 10 cycles after start, busy meanwhile; drop_cmd never completes
  initial begin
    logic [7:0] c;
    forever begin
      @(negedge clk);
      if (rst && eng_start) begin
        c = eng_cmd;
        busy_m = 1'b1;
        repeat (10) @(negedge clk);
        if (c !== drop_cmd) begin
          eng_rdata = (c == 8'h81) ? rd_s : (c == 8'h83) ? rd_m : (c == 8'h85) ? rd_h : 8'h00;
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end
        busy_m = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (eng_start) begin
        n_start++;
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd actual=%h%h required=none", eng_cmd, eng_wdata);
        end else begin
          chk("cmd", {eng_cmd, eng_wdata}, cmd_q.pop_front());
        end
      end
      if (time_valid) begin
        n_tv++;
        if (tv_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_time_valid actual=%h%h%h required=none", time_sec, time_min, time_hour);
        end else begin
          chk("time", {time_sec, time_min, time_hour}, tv_q.pop_front());
        end
        chk("busy_at_time_valid", busy, 0);
      end
      if (wr_ack) begin
        n_ack++;
        chk("busy_at_wr_ack", busy, 0);
      end
      if (err) begin
        n_err++;
        chk("busy_at_err", busy, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Reset state and test 1: first poll right after release
    rd_s = 8'h59; rd_m = 8'h34; rd_h = 8'h12;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {wr_ack, eng_start, time_valid, busy, err, eng_cmd, eng_wdata}, 0);
    chk("reset_time", {time_sec, time_min, time_hour}, 0);
    expect_read(8'h59, 8'h34, 8'h12);
    rst = 1'b1;
    wait_cnt("t1_time_valid", 0, 1, 200);
    chk("t1_cmdq_empty", cmd_q.size(), 0);

    // Test 2: time-set write sequence
    cmd_q.push_back(16'h8E00); cmd_q.push_back(16'h8030); cmd_q.push_back(16'h8245);
    cmd_q.push_back(16'h8423); cmd_q.push_back(16'h8E80);
    @(negedge clk);
    pulse_wr(8'h30, 8'h45, 8'h23);
    wait_cnt("t2_wr_ack", 1, 1, 200);
    chk("t2_cmdq_empty", cmd_q.size(), 0);

    // Test 4: masking of CH and 12/24h bits on the poll at cycle 300
    rd_s = 8'hD9; rd_m = 8'h34; rd_h = 8'hE3;
    expect_read(8'h59, 8'h34, 8'h23);
    wait_cnt("t4_time_valid", 0, 2, 400);
    chk("t4_cmdq_empty", cmd_q.size(), 0);

    // Test 3: wr_req sampled on the same edge the poll counter expires (edge 600)
    for (int i = 0; i < 700 && cyc != POLL * 2 - 1; i++) @(negedge clk);
    chk("t3_align", cyc, POLL * 2 - 1);
    cmd_q.push_back(16'h8E00); cmd_q.push_back(16'h8012); cmd_q.push_back(16'h8234);
    cmd_q.push_back(16'h8405); cmd_q.push_back(16'h8E80);
    rd_s = 8'h07; rd_m = 8'h08; rd_h = 8'h09;
    expect_read(8'h07, 8'h08, 8'h09);
    pulse_wr(8'h12, 8'h34, 8'h05);
    wait_cnt("t3_wr_ack", 1, 2, 300);
    wait_cnt("t3_time_valid", 0, 3, 300);
    chk("t3_cmdq_empty", cmd_q.size(), 0);

    // Test 5: minutes read never completes -> timeout, time unchanged, next poll normal
    drop_cmd = 8'h83;
    rd_s = 8'h44; rd_m = 8'h55; rd_h = 8'h16;
    cmd_q.push_back(16'h8100); cmd_q.push_back(16'h8300);
    wait_cnt("t5_err", 2, 1, 600);
    chk("t5_time_held", {time_sec, time_min, time_hour}, 24'h070809);
    chk("t5_no_time_valid", n_tv, 3);
    drop_cmd = 8'h00;
    expect_read(8'h44, 8'h55, 8'h16);
    wait_cnt("t5_next_poll", 0, 4, 400);
    chk("t5_err_single", n_err, 1);
    chk("t5_cmdq_empty", cmd_q.size(), 0);

    // Test 6: engine busy blocks issue; then reset mid-write loses the write
    busy_force = 1'b1;
    cmd_q.push_back(16'h8E00); cmd_q.push_back(16'h8011); cmd_q.push_back(16'h8222);
    cmd_q.push_back(16'h8413); cmd_q.push_back(16'h8E80);
    begin
      int s0;
      s0 = n_start;
      pulse_wr(8'h11, 8'h22, 8'h13);
      repeat (50) @(negedge clk);
      chk("t6_start_withheld", n_start, s0);
      busy_force = 1'b0;
      wait_cnt("t6_write_started", 3, s0 + 2, 100);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_reset_ctrl", {wr_ack, eng_start, time_valid, busy, err, eng_cmd, eng_wdata}, 0);
    chk("t6_reset_time", {time_sec, time_min, time_hour}, 0);
    chk("t6_pending_cmds", cmd_q.size(), 3);
    cmd_q.delete();
    tv_q.delete();
    rd_s = 8'h21; rd_m = 8'h43; rd_h = 8'h08;
    expect_read(8'h21, 8'h43, 8'h08);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_cnt("t6_poll_after_reset", 0, 5, 300);
    repeat (100) @(negedge clk);
    chk("t6_write_lost", n_ack, 2);
    chk("t6_cmdq_empty", cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
